i2c_bus_monitor_wb: RTL and testbench
=====================================

I2C_BUS_MONITOR_WB -- requirements
Module: i2c_bus_monitor_wb

Interface
REQ-001 Parameter NUM_BUSES, default 1, number of monitored I2C buses (1..16).
REQ-002 Parameter FIFO_DEPTH, default 16, capture FIFO entries (power of two, 4..64).
REQ-003 Port clk_i  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_i  input  1  synchronous, active-high reset.
REQ-005 Ports cyc_i, stb_i, we_i  input  1 each  Wishbone slave cycle, strobe, write enable.
REQ-006 Port adr_i  input  2  register address; dat_i  input  8  write data.
REQ-007 Port dat_o  output  8  read data; ack_o  output  1  Wishbone acknowledge.
REQ-008 Port irq_o  output  1  interrupt request, level.
REQ-009 Ports scl_i, sda_i  input  NUM_BUSES each  I2C lines; observed only, never driven.

Function
REQ-010 Registers: adr 0 CSR (bit7 EN, bit6 IE, bits3:0 BUS_SEL); adr 1 DATA (read pops head byte); adr 2 STAT (bit7 EMPTY, bit6 FULL, bit5 OVF, bit1 head FIRST, bit0 head NACK); adr 3 LEVEL (FIFO fill count).
REQ-011 Wishbone: ack_o high exactly one cycle after cyc_i&stb_i sampled with ack_o low; one ack per access; dat_o valid with ack_o.
REQ-012 Writes to DATA and LEVEL are ignored; a STAT write of 1 to bit5 clears OVF; other STAT bits are read-only.
REQ-013 BUS_SEL >= NUM_BUSES selects bus 0.
REQ-014 The selected scl/sda pass through a 2-flop synchronizer before detection.
REQ-015 START = synchronized sda falling while scl high; STOP = sda rising while scl high.
REQ-016 FSM states IDLE, BYTE, ACK; reset state IDLE.
REQ-017 IDLE -> BYTE on START; bit counter cleared; FIRST flag set for the next byte.
REQ-018 BYTE: sample sda on each scl rising edge, MSB first; after the 8th bit -> ACK.
REQ-019 ACK: sample sda on the 9th scl rise; push {FIRST, NACK=sda, byte} into the FIFO; clear FIRST; -> BYTE.
REQ-020 STOP in any state -> IDLE; a partial byte is discarded.
REQ-021 Repeated START in BYTE or ACK -> BYTE with counter cleared and FIRST set; the partial byte is discarded.
REQ-022 EN=0 or a BUS_SEL write forces the FSM to IDLE; FIFO contents are retained.
REQ-023 Push when FULL with no simultaneous pop: entry dropped, OVF set (sticky).
REQ-024 Push and pop in the same cycle, including when FULL: both take effect, LEVEL unchanged, OVF not set.
REQ-025 A DATA read when EMPTY returns 0x00 and pops nothing.
REQ-026 irq_o = IE & (~EMPTY | OVF), registered, one cycle after the condition.

Reset
REQ-027 rst_i high: CSR=0x00, FIFO empty, OVF=0, FSM IDLE, synchronizers=1, ack_o=0, dat_o=0x00, irq_o=0.
REQ-028 Reset asserted mid-transfer or mid-Wishbone access aborts it; no ack_o is issued for that access.

Configuration
REQ-029 Macro I2C_MON_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer, adding 2 cycles of detection latency and rejecting pulses of 1 clk_i or less.
REQ-030 Macro undefined: no filter; detection uses the synchronizer outputs directly.

Structure
REQ-031 Shared package i2c_mon_pkg holds the register address constants, the CSR/STAT bit positions, the FSM state enum and the packed FIFO record type {first, nack, data[7:0]}.
REQ-032 The FIFO is the sub-module i2c_mon_fifo, parametrised by depth and record type, and provides full, empty and level outputs.

Verification
REQ-033 CSR=0xC0; master writes addr 0x22+W, data 0xA5, ACK both, STOP -> LEVEL=2; STAT=0x02 then DATA=0x44; STAT=0x00 then DATA=0xA5; irq_o falls after the second pop.
REQ-034 Read transfer: addr 0x23+R, data 0x5A with master NACK -> entries {FIRST,ACK,0x47} then {NACK,0x5A}.
REQ-035 FIFO_DEPTH=4, CSR=0x80; push 5 bytes -> LEVEL=4, STAT=0x60; writing STAT=0x20 clears OVF to give STAT=0x40.
REQ-036 Repeated START after 4 bits of a data byte -> partial byte absent; the next byte has FIRST=1.
REQ-037 NUM_BUSES=4, BUS_SEL=2; traffic on bus 1 -> LEVEL stays 0; traffic on bus 2 -> captured.
REQ-038 With I2C_MON_GLITCH_FILTER_EN defined, a 1-cycle sda low pulse while scl is high -> no START detected; without the macro -> START and then STOP detected, FSM returns to IDLE, LEVEL=0.

Source files
------------

// File: rtl/i2c_mon_pkg.sv
// rtl/i2c_mon_pkg.sv - register map, FSM states and capture record shared by the I2C bus monitor
package i2c_mon_pkg;

  localparam logic [1:0] ADR_CSR   = 2'd0;
  localparam logic [1:0] ADR_DATA  = 2'd1;
  localparam logic [1:0] ADR_STAT  = 2'd2;
  localparam logic [1:0] ADR_LEVEL = 2'd3;

  localparam int CSR_EN = 7;
  localparam int CSR_IE = 6;
  localparam logic [7:0] CSR_MASK = 8'hCF;

  localparam int STAT_EMPTY = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_OVF   = 5;
  localparam int STAT_FIRST = 1;
  localparam int STAT_NACK  = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  typedef struct packed {
    logic       first;
    logic       nack;
    logic [7:0] data;
  } mon_rec_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor_wb_if.sv
// rtl/i2c_bus_monitor_wb_if.sv - Wishbone register port of the I2C bus monitor
interface i2c_bus_monitor_wb_if;

  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [1:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

endinterface

// File: rtl/i2c_mon_fifo.sv
// rtl/i2c_mon_fifo.sv - synchronous capture FIFO; a pop on a full FIFO frees room for a same-cycle push
module i2c_mon_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T             mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_bus_monitor_wb.sv
// rtl/i2c_bus_monitor_wb.sv - passive I2C byte capture with Wishbone readout; I2C_MON_GLITCH_FILTER_EN adds a majority filter
module i2c_bus_monitor_wb
  import i2c_mon_pkg::*;
#(
  parameter int NUM_BUSES  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  i2c_bus_monitor_wb_if.slave  wb,
  output logic                 irq_o,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0] csr;
  logic       ovf;
  logic       en;
  logic       ie;
  logic [3:0] bus_sel;

  assign en      = csr[CSR_EN];
  assign ie      = csr[CSR_IE];
  assign bus_sel = csr[3:0];

  logic wb_req;
  logic wb_wr;
  logic wb_rd;
  logic csr_wr;
  logic pop;

  assign wb_req = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign wb_wr  = wb_req & wb.we_i;
  assign wb_rd  = wb_req & ~wb.we_i;
  assign csr_wr = wb_wr & (wb.adr_i == ADR_CSR);
  assign pop    = wb_rd & (wb.adr_i == ADR_DATA);

  // out-of-range selects fall back to bus 0 because no loop iteration matches
  logic scl_mux;
  logic sda_mux;
  always_comb begin
    scl_mux = scl_i[0];
    sda_mux = sda_i[0];
    for (int i = 1; i < NUM_BUSES; i++) begin
      if (int'(bus_sel) == i) begin
        scl_mux = scl_i[i];
        sda_mux = sda_i[i];
      end
    end
  end

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_mux};
      sda_sync <= {sda_sync[0], sda_mux};
    end
  end

  logic scl_s;
  logic sda_s;
`ifdef I2C_MON_GLITCH_FILTER_EN
  logic [2:0] scl_flt;
  logic [2:0] sda_flt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_flt <= 3'b111;
      sda_flt <= 3'b111;
    end else begin
      scl_flt <= {scl_flt[1:0], scl_sync[1]};
      sda_flt <= {sda_flt[1:0], sda_sync[1]};
    end
  end
  assign scl_s = maj3(scl_flt);
  assign sda_s = maj3(sda_flt);
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  logic scl_d;
  logic sda_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  logic start_det;
  logic stop_det;
  logic scl_rise;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise  = scl_s & ~scl_d;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       first;
  logic       push;
  mon_rec_t   push_rec;

  assign push     = en & ~csr_wr & ~start_det & ~stop_det & (state == ST_ACK) & scl_rise;
  assign push_rec = '{first: first, nack: sda_s, data: shreg};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      first   <= 1'b0;
    end else if (!en || csr_wr) begin
      state <= ST_IDLE;
    end else if (stop_det) begin
      state <= ST_IDLE;
    end else if (start_det) begin
      state   <= ST_BYTE;
      bit_cnt <= 3'd0;
      first   <= 1'b1;
    end else begin
      case (state)
        ST_BYTE: begin
          if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (scl_rise) begin
            first   <= 1'b0;
            bit_cnt <= 3'd0;
            state   <= ST_BYTE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mon_rec_t        head;
  logic            full;
  logic            empty;
  logic [LW-1:0]   level;

  i2c_mon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (mon_rec_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  logic [7:0] stat;
  logic [7:0] rd_data;
  always_comb begin
    stat             = 8'h00;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL]  = full;
    stat[STAT_OVF]   = ovf;
    stat[STAT_FIRST] = ~empty & head.first;
    stat[STAT_NACK]  = ~empty & head.nack;
    case (wb.adr_i)
      ADR_CSR:  rd_data = csr;
      ADR_DATA: rd_data = empty ? 8'h00 : head.data;
      ADR_STAT: rd_data = stat;
      default:  rd_data = 8'(level);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr      <= 8'h00;
      ovf      <= 1'b0;
      wb.ack_o <= 1'b0;
      wb.dat_o <= 8'h00;
      irq_o    <= 1'b0;
    end else begin
      wb.ack_o <= wb_req;
      wb.dat_o <= wb_rd ? rd_data : 8'h00;
      if (csr_wr) csr <= wb.dat_i & CSR_MASK;
      // a drop in the same cycle as a clear keeps the flag so the loss is never hidden
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (wb_wr && wb.adr_i == ADR_STAT && wb.dat_i[STAT_OVF])
        ovf <= 1'b0;
      irq_o <= ie & (~empty | ovf);
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor_wb.sv
// tb/tb_i2c_bus_monitor_wb.sv - randomized I2C traffic checked against a queue model of captured bytes
module tb_i2c_bus_monitor_wb;
  import i2c_mon_pkg::*;

  localparam int NB  = 4;
  localparam int DEPTH = 4;
  localparam int TPH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] scl = '1;
  logic [NB-1:0] sda = '1;
  logic          irq;

  i2c_bus_monitor_wb_if wb();

  i2c_bus_monitor_wb #(
    .NUM_BUSES  (NB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb),
    .irq_o (irq),
    .scl_i (scl),
    .sda_i (sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    act;
    int    exp;
  } chk_t;

  chk_t  req_q[$];
  int    exp_q[$];
  string nm_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // model: each record is first*512 + nack*256 + data
  int         m_q[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_csr = 8'h00;
  bit         m_first = 1'b0;

  function automatic bit m_capt(input int bus);
    int sel;
    sel = int'(m_csr[3:0]);
    if (sel >= NB) sel = 0;
    return m_csr[7] && (bus == sel);
  endfunction

  function automatic void m_push(input int rec);
    if (m_q.size() < DEPTH) m_q.push_back(rec);
    else m_ovf = 1'b1;
  endfunction

  function automatic int m_stat();
    int s;
    s = 0;
    if (m_q.size() == 0) s += 128;
    if (m_q.size() == DEPTH) s += 64;
    if (m_ovf) s += 32;
    if (m_q.size() > 0) s += m_q[0] / 256;
    return s;
  endfunction

  function automatic int m_read(input int adr);
    int v;
    v = 0;
    case (adr)
      0: v = int'(m_csr) & 8'hCF;
      1: if (m_q.size() > 0) v = m_q.pop_front() % 256;
      2: v = m_stat();
      default: v = m_q.size();
    endcase
    return v;
  endfunction

  function automatic int m_irq();
    return (m_csr[6] && (m_q.size() != 0 || m_ovf)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    chk_t  c;
    int    e;
    string n;
    if (wb.ack_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_ack: ack_o=1 with no access pending, required 0");
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (int'(wb.dat_o) != e) begin
          miscompares++;
          $display("FAIL %s: dat_o=%02h required %02h", n, wb.dat_o, e);
        end
      end
    end
    while (req_q.size() != 0) begin
      c = req_q.pop_front();
      vectors++;
      if (c.act != c.exp) begin
        miscompares++;
        $display("FAIL %s: got %0h required %0h", c.nm, c.act, c.exp);
      end
    end
  end

  task automatic post(input string nm, input int act, input int exp);
    chk_t c;
    c.nm = nm;
    c.act = act;
    c.exp = exp;
    req_q.push_back(c);
  endtask

  task automatic wb_acc(input bit we, input int adr, input int d, input int exp, input string nm);
    int n;
    n = 0;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = we;
    wb.adr_i = 2'(adr);
    wb.dat_i = 8'(d);
    do begin
      @(negedge clk);
      n++;
    end while (!wb.ack_o && n < 10);
    if (!wb.ack_o) begin
      $display("FAIL %s_ack: no ack after %0d cycles, required 1", nm, n);
      $fatal(1, "wishbone ack timeout");
    end
    post({nm, "_ack_lat"}, n, 1);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
    @(negedge clk);
    post({nm, "_single_ack"}, int'(wb.ack_o), 0);
    post({nm, "_irq"}, int'(irq), m_irq());
  endtask

  task automatic rd(input int adr, input string nm);
    int e;
    e = m_read(adr);
    wb_acc(1'b0, adr, 0, e, nm);
  endtask

  task automatic rd_lit(input int adr, input int lit, input string nm);
    int e;
    e = m_read(adr);
    post({nm, "_model"}, e, lit);
    wb_acc(1'b0, adr, 0, lit, nm);
  endtask

  task automatic wr(input int adr, input int d, input string nm);
    if (adr == 0) m_csr = 8'(d);
    if (adr == 2 && d[5]) m_ovf = 1'b0;
    wb_acc(1'b1, adr, d, 0, nm);
  endtask

  task automatic ph();
    repeat (TPH) @(negedge clk);
  endtask

  task automatic i2c_start(input int b);
    sda[b] = 1'b1; ph();
    scl[b] = 1'b1; ph();
    sda[b] = 1'b0; ph();
    scl[b] = 1'b0; ph();
    m_first = 1'b1;
  endtask

  task automatic i2c_bit(input int b, input bit v);
    sda[b] = v;    ph();
    scl[b] = 1'b1; ph();
    scl[b] = 1'b0; ph();
  endtask

  task automatic i2c_byte(input int b, input int d, input bit nack);
    for (int i = 7; i >= 0; i--) i2c_bit(b, d[i]);
    i2c_bit(b, nack);
    if (m_capt(b)) begin
      m_push((m_first ? 512 : 0) + (nack ? 256 : 0) + (d % 256));
      m_first = 1'b0;
    end
  endtask

  task automatic i2c_partial(input int b, input int d, input int n);
    for (int i = 0; i < n; i++) i2c_bit(b, d[7-i]);
  endtask

  task automatic i2c_stop(input int b);
    sda[b] = 1'b0; ph();
    scl[b] = 1'b1; ph();
    sda[b] = 1'b1; ph();
  endtask

  initial begin
    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    wb.we_i  = 1'b0;
    wb.adr_i = 2'd0;
    wb.dat_i = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    post("rst_ack", int'(wb.ack_o), 0);
    post("rst_dat", int'(wb.dat_o), 0);
    post("rst_irq", int'(irq), 0);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    post("post_rst_ack", int'(wb.ack_o), 0);

    rd_lit(ADR_CSR,   8'h00, "rst_csr");
    rd_lit(ADR_STAT,  8'h80, "rst_stat");
    rd_lit(ADR_LEVEL, 0,     "rst_level");
    rd_lit(ADR_DATA,  8'h00, "rst_empty_data");

    wb.cyc_i = 1'b1;
    wb.stb_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    post("mid_access_rst_ack", int'(wb.ack_o), 0);
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    post("mid_access_rst_ack2", int'(wb.ack_o), 0);

    // write transfer: address byte then one data byte
    wr(ADR_CSR, 8'hC0, "w_csr");
    i2c_start(0);
    i2c_byte(0, 8'h44, 1'b0);
    i2c_byte(0, 8'hA5, 1'b0);
    i2c_stop(0);
    rd_lit(ADR_LEVEL, 2, "wr_level");
    post("wr_irq_high", int'(irq), 1);
    rd_lit(ADR_STAT, 8'h02, "wr_stat0");
    rd_lit(ADR_DATA, 8'h44, "wr_data0");
    rd_lit(ADR_STAT, 8'h00, "wr_stat1");
    rd_lit(ADR_DATA, 8'hA5, "wr_data1");
    post("wr_irq_fall", int'(irq), 0);

    // read transfer ending with a master NACK
    i2c_start(0);
    i2c_byte(0, 8'h47, 1'b0);
    i2c_byte(0, 8'h5A, 1'b1);
    i2c_stop(0);
    rd_lit(ADR_STAT, 8'h02, "rd_stat0");
    rd_lit(ADR_DATA, 8'h47, "rd_data0");
    rd_lit(ADR_STAT, 8'h01, "rd_stat1");
    rd_lit(ADR_DATA, 8'h5A, "rd_data1");

    // overflow: drain the address byte, then five data bytes into a 4-deep FIFO
    wr(ADR_CSR, 8'h80, "ovf_csr");
    i2c_start(0);
    i2c_byte(0, 8'h44, 1'b0);
    rd_lit(ADR_DATA, 8'h44, "ovf_addr");
    for (int k = 0; k < 5; k++) i2c_byte(0, 8'h10 + k, 1'b0);
    i2c_stop(0);
    rd_lit(ADR_LEVEL, 4, "ovf_level");
    rd_lit(ADR_STAT, 8'h60, "ovf_stat");
    wr(ADR_STAT, 8'h20, "ovf_clear");
    rd_lit(ADR_STAT, 8'h40, "ovf_stat_clr");
    rd_lit(ADR_DATA, 8'h10, "ovf_head");
    for (int k = 0; k < 3; k++) rd(ADR_DATA, "ovf_drain");

    // repeated START four bits into a data byte
    wr(ADR_CSR, 8'hC0, "rs_csr");
    i2c_start(0);
    i2c_byte(0, 8'h44, 1'b0);
    i2c_partial(0, 8'hB0, 4);
    i2c_start(0);
    i2c_byte(0, 8'h3C, 1'b0);
    i2c_stop(0);
    rd_lit(ADR_LEVEL, 2, "rs_level");
    rd_lit(ADR_STAT, 8'h02, "rs_stat0");
    rd_lit(ADR_DATA, 8'h44, "rs_data0");
    rd_lit(ADR_STAT, 8'h02, "rs_stat1");
    rd_lit(ADR_DATA, 8'h3C, "rs_data1");

    // bus selection
    wr(ADR_CSR, 8'hC2, "sel_csr");
    i2c_start(1);
    i2c_byte(1, 8'h44, 1'b0);
    i2c_stop(1);
    rd_lit(ADR_LEVEL, 0, "sel_bus1_level");
    i2c_start(2);
    i2c_byte(2, 8'h44, 1'b0);
    i2c_stop(2);
    rd_lit(ADR_LEVEL, 1, "sel_bus2_level");
    rd_lit(ADR_DATA, 8'h44, "sel_bus2_data");
    rd_lit(ADR_CSR, 8'hC2, "sel_csr_rb");

    // one-cycle SDA glitch while SCL is high never captures anything
    wr(ADR_CSR, 8'hC0, "gl_csr");
    @(negedge clk) sda[0] = 1'b0;
    @(negedge clk) sda[0] = 1'b1;
    repeat (20) @(negedge clk);
    rd_lit(ADR_LEVEL, 0, "gl_level");
    i2c_start(0);
    i2c_byte(0, 8'h96, 1'b1);
    i2c_stop(0);
    rd_lit(ADR_LEVEL, 1, "gl_after_level");
    rd_lit(ADR_STAT, 8'h03, "gl_after_stat");
    rd(ADR_DATA, "gl_after_data");

    for (int it = 0; it < 25; it++) begin
      int bus;
      int nby;
      int csrv;
      int r;
      csrv = (($urandom_range(0, 7) != 0) ? 128 : 0)
           + (($urandom_range(0, 1) != 0) ? 64 : 0)
           + int'($urandom_range(0, 15));
      wr(ADR_CSR, csrv, "rnd_csr");
      bus = int'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 1) != 0) begin
        bus = csrv % 16;
        if (bus >= NB) bus = 0;
      end
      i2c_start(bus);
      nby = int'($urandom_range(1, 3));
      for (int k = 0; k < nby; k++)
        i2c_byte(bus, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        i2c_partial(bus, int'($urandom_range(0, 255)), int'($urandom_range(1, 7)));
        i2c_start(bus);
        i2c_byte(bus, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      i2c_stop(bus);
      r = int'($urandom_range(1, 4));
      for (int k = 0; k < r; k++) rd(int'($urandom_range(0, 3)), "rnd_rd");
      if ($urandom_range(0, 3) == 0) wr(ADR_STAT, 8'h20, "rnd_ovf_clr");
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
